// File: rtl/pipe_pkg.sv
// Shared constants and occupancy decode for the pipeline skid latch.
package pipe_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_NUM_OPS = 2;
  localparam logic [31:0] NOP_ENC     = 32'h0000_0000;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_HEAD  = 2'b01,
    OCC_FULL  = 2'b11,
    OCC_BAD   = 2'b10
  } occ_e;

  // Skid is only ever filled behind a valid head; OCC_BAD is unreachable.
  function automatic occ_e occ_of(input logic main_v, input logic skid_v);
    occ_e occ;
    if (!main_v && !skid_v)     occ = OCC_EMPTY;
    else if (main_v && !skid_v) occ = OCC_HEAD;
    else if (main_v && skid_v)  occ = OCC_FULL;
    else                        occ = OCC_BAD;
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_latch_if.sv
// Valid/ready handshake bundle on both sides of a pipeline latch.
interface pipe_skid_latch_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_OPS = 2
);

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_OPS*WIDTH-1:0] op_in;
  logic [WIDTH-1:0]         ir_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_OPS*WIDTH-1:0] op_out;
  logic [WIDTH-1:0]         ir_out;

  modport master (
    output in_valid, op_in, ir_in, out_ready,
    input  in_ready, out_valid, op_out, ir_out
  );

  modport slave (
    input  in_valid, op_in, ir_in, out_ready,
    output in_ready, out_valid, op_out, ir_out
  );

endinterface

// File: rtl/pipe_entry.sv
// One payload register set (valid, operands, IR) with load and clear-to-bubble.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter int unsigned      NUM_OPS = DEF_NUM_OPS,
  parameter logic [WIDTH-1:0] NOP_IR  = WIDTH'(NOP_ENC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     clear,
  input  logic [NUM_OPS*WIDTH-1:0] op_d,
  input  logic [WIDTH-1:0]         ir_d,
  output logic                     valid_q,
  output logic [NUM_OPS*WIDTH-1:0] op_q,
  output logic [WIDTH-1:0]         ir_q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      ir_q    <= NOP_IR;
    end else if (clear) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      ir_q    <= NOP_IR;
    end else if (load) begin
      valid_q <= 1'b1;
      op_q    <= op_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: rtl/pipe_skid_latch.sv
// Inter-stage pipeline latch: valid/ready handshake, 2-entry skid, flush, stall counter.
module pipe_skid_latch
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter int unsigned      NUM_OPS = DEF_NUM_OPS,
  parameter logic [WIDTH-1:0] NOP_IR  = WIDTH'(NOP_ENC),
  parameter int unsigned      CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_skid_latch_if.slave  bus,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic                     main_v, skid_v;
  logic [NUM_OPS*WIDTH-1:0] main_op, skid_op, main_op_d;
  logic [WIDTH-1:0]         main_ir, skid_ir, main_ir_d;
  logic                     main_ld, main_clr, main_from_skid;
  logic                     skid_ld, skid_clr;
  logic                     acc, drn;
  occ_e                     occ;

  // in_ready comes straight from the skid flop, so out_ready never reaches upstream.
  assign bus.in_ready  = ~skid_v;
  assign bus.out_valid = main_v;
  assign bus.op_out    = main_v ? main_op : '0;
  assign bus.ir_out    = main_v ? main_ir : NOP_IR;

  assign acc = bus.in_valid & ~skid_v;
  assign drn = main_v & bus.out_ready;
  assign occ = occ_of(main_v, skid_v);

  always_comb begin
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (occ)
        OCC_EMPTY: main_ld = acc;
        OCC_HEAD: begin
          if (drn) begin
            main_ld  = acc;
            main_clr = ~acc;
          end else begin
            skid_ld = acc;
          end
        end
        OCC_FULL: begin
          if (drn) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_op_d = main_from_skid ? skid_op : bus.op_in;
  assign main_ir_d = main_from_skid ? skid_ir : bus.ir_in;

  pipe_entry #(
    .WIDTH   (WIDTH),
    .NUM_OPS (NUM_OPS),
    .NOP_IR  (NOP_IR)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_ld),
    .clear   (main_clr),
    .op_d    (main_op_d),
    .ir_d    (main_ir_d),
    .valid_q (main_v),
    .op_q    (main_op),
    .ir_q    (main_ir)
  );

  pipe_entry #(
    .WIDTH   (WIDTH),
    .NUM_OPS (NUM_OPS),
    .NOP_IR  (NOP_IR)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_ld),
    .clear   (skid_clr),
    .op_d    (bus.op_in),
    .ir_d    (bus.ir_in),
    .valid_q (skid_v),
    .op_q    (skid_op),
    .ir_q    (skid_ir)
  );

  // Flush does not touch the counter; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_v && !bus.out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed self-checking bench for pipe_skid_latch (WIDTH=32, NUM_OPS=2, CNT_W=4).
module tb_pipe_skid_latch;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_OPS = 2;
  localparam int unsigned CNT_W   = 4;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic             clk;
  logic             reset;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  int               checks;
  int               errors;
  int               exp_stall;

  pipe_skid_latch_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) bus ();

  pipe_skid_latch #(
    .WIDTH   (WIDTH),
    .NUM_OPS (NUM_OPS),
    .NOP_IR  (NOP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [63:0] ops);
    bus.in_valid = v;
    bus.ir_in    = ir;
    bus.op_in    = ops;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [31:0] ir,
                         input logic [63:0] ops, input logic rdy);
    checks++;
    if (bus.out_valid !== v || bus.ir_out !== ir || bus.op_out !== ops ||
        bus.in_ready !== rdy) begin
      errors++;
      $display("FAIL %s: got v=%b ir=%h op=%h rdy=%b, want v=%b ir=%h op=%h rdy=%b",
               name, bus.out_valid, bus.ir_out, bus.op_out, bus.in_ready, v, ir, ops, rdy);
    end
  endtask

  task automatic chk_stall(input string name, input int want);
    checks++;
    if (stall_cnt !== CNT_W'(want)) begin
      errors++;
      $display("FAIL %s: stall_cnt got %0d want %0d", name, stall_cnt, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    #12;
    chk_out("reset_during", 1'b0, NOP, 64'h0, 1'b1);
    chk_stall("reset_during_stall", 0);
    #1 reset = 1'b0;
    step();
    step();
    chk_out("reset_release", 1'b0, NOP, 64'h0, 1'b1);
    chk_stall("reset_release_stall", 0);
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1'b1, 32'h11 + i, {32'hB0 + i, 32'hA0 + i});
      step();
      chk_out($sformatf("stream_beat%0d", i), 1'b1, 32'h11 + i,
              {32'hB0 + i, 32'hA0 + i}, 1'b1);
    end
    drive(1'b0, 32'h0, 64'h0);
    step();
    chk_out("stream_drained", 1'b0, NOP, 64'h0, 1'b1);
    chk_stall("stream_stall", exp_stall);
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h21, 64'h0000_0002_0000_0001);
    step();
    chk_out("bp_first", 1'b1, 32'h21, 64'h0000_0002_0000_0001, 1'b1);
    drive(1'b1, 32'h22, 64'h0000_0004_0000_0003);
    step();
    exp_stall++;
    drive(1'b0, 32'h0, 64'h0);
    chk_out("bp_skid_full", 1'b1, 32'h21, 64'h0000_0002_0000_0001, 1'b0);
    step();
    exp_stall++;
    chk_out("bp_held", 1'b1, 32'h21, 64'h0000_0002_0000_0001, 1'b0);
    chk_stall("bp_stall2", exp_stall);
    bus.out_ready = 1'b1;
    #1;
    chk_out("bp_deliver_first", 1'b1, 32'h21, 64'h0000_0002_0000_0001, 1'b0);
    step();
    chk_out("bp_deliver_second", 1'b1, 32'h22, 64'h0000_0004_0000_0003, 1'b1);
    step();
    chk_out("bp_empty", 1'b0, NOP, 64'h0, 1'b1);
    chk_stall("bp_stall_hold", exp_stall);
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h31, 64'h5);
    step();
    drive(1'b1, 32'h32, 64'h6);
    step();
    exp_stall++;
    chk_out("flush_pre_full", 1'b1, 32'h31, 64'h5, 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'h33, 64'h7);
    step();
    exp_stall++;
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    chk_out("flush_cleared", 1'b0, NOP, 64'h0, 1'b1);
    chk_stall("flush_keeps_stall", exp_stall);
    bus.out_ready = 1'b1;
    step();
    chk_out("flush_no_ghost", 1'b0, NOP, 64'h0, 1'b1);
    // beat accepted in the flush cycle is discarded
    flush = 1'b1;
    drive(1'b1, 32'h34, 64'h8);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    chk_out("flush_drops_acc", 1'b0, NOP, 64'h0, 1'b1);
    // drain in flush cycle: head visible with out_ready=1 before the edge
    drive(1'b1, 32'h35, 64'h9);
    step();
    drive(1'b0, 32'h0, 64'h0);
    flush = 1'b1;
    #1;
    chk_out("flush_drain_visible", 1'b1, 32'h35, 64'h9, 1'b1);
    step();
    flush = 1'b0;
    chk_out("flush_after_drain", 1'b0, NOP, 64'h0, 1'b1);
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h41, 64'hCAFE);
    step();
    drive(1'b0, 32'h0, 64'h0);
    for (int unsigned i = 0; i < (1 << CNT_W) + 5; i++) step();
    chk_stall("stall_saturate", 15);
    chk_out("stall_head_held", 1'b1, 32'h41, 64'hCAFE, 1'b1);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h51, 64'hBEEF);
    step();
    drive(1'b0, 32'h0, 64'h0);
    chk_out("ar_both_full", 1'b1, 32'h41, 64'hCAFE, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_out("ar_immediate", 1'b0, NOP, 64'h0, 1'b1);
    chk_stall("ar_stall_zero", 0);
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h61, 64'h1234);
    step();
    drive(1'b0, 32'h0, 64'h0);
    chk_out("ar_recover", 1'b1, 32'h61, 64'h1234, 1'b1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_stall = 0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
